// File: rtl/clk_div_gen_if.sv
// Bundle for clk_div_gen: run request, half-period config handshake, divided clock and strobes.
// Optional CLKDIV_TAPS_EN adds the clk_d2/clk_d4 taps.
interface clk_div_gen_if #(
  parameter int CNT_W  = 8,
  parameter int PCNT_W = 16
);
  logic              en;
  logic              cfg_valid;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_ready;
  logic              cfg_done;
  logic              cfg_err;
  logic              clk_out;
  logic              rise;
  logic              fall;
  logic [PCNT_W-1:0] period_cnt;
  logic              busy;
`ifdef CLKDIV_TAPS_EN
  logic              clk_d2;
  logic              clk_d4;

  modport master (
    output en, cfg_valid, cfg_half,
    input  cfg_ready, cfg_done, cfg_err, clk_out, rise, fall, period_cnt, busy, clk_d2, clk_d4
  );
  modport slave (
    input  en, cfg_valid, cfg_half,
    output cfg_ready, cfg_done, cfg_err, clk_out, rise, fall, period_cnt, busy, clk_d2, clk_d4
  );
`else
  modport master (
    output en, cfg_valid, cfg_half,
    input  cfg_ready, cfg_done, cfg_err, clk_out, rise, fall, period_cnt, busy
  );
  modport slave (
    input  en, cfg_valid, cfg_half,
    output cfg_ready, cfg_done, cfg_err, clk_out, rise, fall, period_cnt, busy
  );
`endif
endinterface

// File: rtl/clk_div_gen.sv
// Divided clock (period 2*H) with registered rise/fall strobes; starts on the edge en is seen, 1-deep config
// buffer (cfg_ready low while a value is pending, applied on a period boundary). CLKDIV_TAPS_EN adds clk_d2/clk_d4.
module clk_div_gen #(
  parameter int CNT_W    = 8,
  parameter int HALF_DEF = 1,
  parameter int PCNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  clk_div_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [CNT_W-1:0]  CONE     = 1;
  localparam logic [PCNT_W-1:0] PONE     = 1;
  localparam logic [CNT_W-1:0]  HALF_RST = CNT_W'(HALF_DEF);

  state_t            state_q, state_d;
  logic              clk_out_q, clk_out_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  half_cur_q, half_cur_d;
  logic [CNT_W-1:0]  half_pend_q, half_pend_d;
  logic              pend_v_q, pend_v_d;
  logic              cfg_done_q, cfg_done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;
  logic              phase_end;
  logic              apply;
`ifdef CLKDIV_TAPS_EN
  logic              clk_d2_q, clk_d2_d;
  logic              clk_d4_q, clk_d4_d;
`endif

  assign phase_end = (cnt_q == (half_cur_q - CONE));

  always_comb begin
    state_d      = state_q;
    clk_out_d    = clk_out_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    cnt_d        = cnt_q;
    half_cur_d   = half_cur_q;
    half_pend_d  = half_pend_q;
    pend_v_d     = pend_v_q;
    cfg_done_d   = 1'b0;
    cfg_err_d    = 1'b0;
    period_cnt_d = period_cnt_q;
    apply        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        apply     = pend_v_q;
        if (bus.en) begin
          state_d   = RUN;
          clk_out_d = 1'b1;
          rise_d    = 1'b1;
        end
      end
      RUN: begin
        // A low phase may be cut short by en dropping; a high phase never is.
        if (!clk_out_q && !bus.en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (phase_end) begin
          cnt_d     = '0;
          clk_out_d = !clk_out_q;
          if (clk_out_q) begin
            fall_d       = 1'b1;
            period_cnt_d = period_cnt_q + PONE;
            apply        = pend_v_q;
            if (!bus.en) state_d = IDLE;
          end else begin
            rise_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CONE;
          if (clk_out_q && !bus.en) state_d = STOP;
        end
      end
      STOP: begin
        if (phase_end) begin
          cnt_d        = '0;
          clk_out_d    = 1'b0;
          fall_d       = 1'b1;
          period_cnt_d = period_cnt_q + PONE;
          apply        = pend_v_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_out_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    // Apply and accept are exclusive: apply needs pend_v high, accept needs it low.
    if (apply) begin
      half_cur_d = half_pend_q;
      pend_v_d   = 1'b0;
      cfg_done_d = 1'b1;
    end
    if (bus.cfg_valid && !pend_v_q) begin
      if (bus.cfg_half == '0) begin
        cfg_err_d = 1'b1;
      end else begin
        half_pend_d = bus.cfg_half;
        pend_v_d    = 1'b1;
      end
    end
  end

`ifdef CLKDIV_TAPS_EN
  always_comb begin
    clk_d2_d = clk_d2_q;
    clk_d4_d = clk_d4_q;
    if (state_d == IDLE) begin
      clk_d2_d = 1'b0;
      clk_d4_d = 1'b0;
    end else if (rise_d) begin
      clk_d2_d = !clk_d2_q;
      if (clk_d2_q) clk_d4_d = !clk_d4_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_out_q    <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      cnt_q        <= '0;
      half_cur_q   <= HALF_RST;
      half_pend_q  <= HALF_RST;
      pend_v_q     <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      period_cnt_q <= '0;
`ifdef CLKDIV_TAPS_EN
      clk_d2_q     <= 1'b0;
      clk_d4_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clk_out_q    <= clk_out_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      cnt_q        <= cnt_d;
      half_cur_q   <= half_cur_d;
      half_pend_q  <= half_pend_d;
      pend_v_q     <= pend_v_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
      period_cnt_q <= period_cnt_d;
`ifdef CLKDIV_TAPS_EN
      clk_d2_q     <= clk_d2_d;
      clk_d4_q     <= clk_d4_d;
`endif
    end
  end

  assign bus.cfg_ready  = !pend_v_q;
  assign bus.cfg_done   = cfg_done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.clk_out    = clk_out_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef CLKDIV_TAPS_EN
  assign bus.clk_d2     = clk_d2_q;
  assign bus.clk_d4     = clk_d4_q;
`endif

endmodule
